// File: rtl/ft245_sync_device_emu_if.sv
`default_nettype none
// ============================================================================
// Module  : ft245_sync_device_emu_if
// Brief   : FT245 sync-FIFO pin bundle plus the AXIS streams of the emulated chip.
// Revision: 1.0 - initial release
// ============================================================================
interface ft245_sync_device_emu_if #(
  parameter int BUS_WIDTH = 1
);
  logic [8*BUS_WIDTH-1:0] ft245_data_i;
  logic [8*BUS_WIDTH-1:0] ft245_data_o;
  logic                   ft245_data_t;
  logic [BUS_WIDTH-1:0]   ft245_ben_i;
  logic [BUS_WIDTH-1:0]   ft245_ben_o;
  logic                   ft245_rdn;
  logic                   ft245_wrn;
  logic                   ft245_oen;
  logic                   ft245_siwun;
  logic                   ft245_rstn;
  logic                   ft245_rxfn;
  logic                   ft245_txen;
  logic [8*BUS_WIDTH-1:0] s_axis_tdata;
  logic [BUS_WIDTH-1:0]   s_axis_tkeep;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic [8*BUS_WIDTH-1:0] m_axis_tdata;
  logic [BUS_WIDTH-1:0]   m_axis_tkeep;
  logic                   m_axis_tlast;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;

  // Device (chip) side.
  modport slave (
    input  ft245_data_i, ft245_ben_i, ft245_rdn, ft245_wrn, ft245_oen,
           ft245_siwun, ft245_rstn,
           s_axis_tdata, s_axis_tkeep, s_axis_tvalid, m_axis_tready,
    output ft245_data_o, ft245_data_t, ft245_ben_o, ft245_rxfn, ft245_txen,
           s_axis_tready,
           m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  // Host bus master together with the USB-side stream endpoints.
  modport master (
    output ft245_data_i, ft245_ben_i, ft245_rdn, ft245_wrn, ft245_oen,
           ft245_siwun, ft245_rstn,
           s_axis_tdata, s_axis_tkeep, s_axis_tvalid, m_axis_tready,
    input  ft245_data_o, ft245_data_t, ft245_ben_o, ft245_rxfn, ft245_txen,
           s_axis_tready,
           m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/ft245_sync_device_emu.sv
`default_nettype none
// ============================================================================
// Module  : ft245_sync_device_emu
// Brief   : FT245 synchronous-FIFO device emulator, AXIS on the USB side.
// Revision: 1.0 - initial release
// ============================================================================
module ft245_sync_device_emu #(
  parameter int BUS_WIDTH = 1,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16
) (
  input  wire logic              ft245_dclk,
  input  wire logic              rst,
  ft245_sync_device_emu_if.slave bus
);

  localparam int c_DW    = 8 * BUS_WIDTH;
  localparam int c_RX_AW = $clog2(RX_DEPTH);
  localparam int c_TX_AW = $clog2(TX_DEPTH);
  localparam int c_RX_WW = c_DW + BUS_WIDTH;
  localparam int c_TX_WW = c_DW + BUS_WIDTH + 1;
  localparam logic [c_RX_AW:0] c_RX_FULL = {1'b1, {c_RX_AW{1'b0}}};
  localparam logic [c_TX_AW:0] c_TX_FULL = {1'b1, {c_TX_AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_TURN = 2'd1,
    ST_RD      = 2'd2,
    ST_WR      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [c_RX_AW:0]       r_rx_wr_ptr;
  logic [c_RX_AW:0]       r_rx_rd_ptr;
  logic [c_RX_AW:0]       w_rx_wr_ptr_next;
  logic [c_RX_AW:0]       w_rx_rd_ptr_next;
  logic [c_RX_AW:0]       w_rx_count_next;
  logic [c_RX_WW-1:0]     r_rx_mem [RX_DEPTH];
  logic [c_RX_WW-1:0]     w_rx_head_next;
  logic                   w_rx_push;
  logic                   w_rx_pop;

  logic [c_TX_AW:0]       r_tx_wr_ptr;
  logic [c_TX_AW:0]       r_tx_rd_ptr;
  logic [c_TX_AW:0]       w_tx_wr_ptr_next;
  logic [c_TX_AW:0]       w_tx_rd_ptr_next;
  logic [c_TX_AW:0]       w_tx_count_next;
  logic [c_TX_WW-1:0]     r_tx_mem [TX_DEPTH];
  logic [c_TX_WW-1:0]     w_tx_head_next;
  logic [c_TX_WW-1:0]     w_tx_word;
  logic                   w_tx_push;
  logic                   w_tx_pop;

  logic                   r_rxfn;
  logic                   r_txen;
  logic                   r_data_t;
  logic [c_DW-1:0]        r_data_o;
  logic [BUS_WIDTH-1:0]   r_ben_o;
  logic                   r_s_axis_tready;
  logic                   r_m_axis_tvalid;
  logic [c_DW-1:0]        r_m_axis_tdata;
  logic [BUS_WIDTH-1:0]   r_m_axis_tkeep;
  logic                   r_m_axis_tlast;

  // ---------------------------------------------------------------- RX FIFO
  assign w_rx_push        = bus.s_axis_tvalid & r_s_axis_tready;
  assign w_rx_pop         = (r_state == ST_RD) & ~bus.ft245_rdn & ~r_rxfn;
  assign w_rx_wr_ptr_next = r_rx_wr_ptr + {{c_RX_AW{1'b0}}, w_rx_push};
  assign w_rx_rd_ptr_next = r_rx_rd_ptr + {{c_RX_AW{1'b0}}, w_rx_pop};
  assign w_rx_count_next  = w_rx_wr_ptr_next - w_rx_rd_ptr_next;

  always_ff @(posedge ft245_dclk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr_ptr[c_RX_AW-1:0]] <= {bus.s_axis_tkeep, bus.s_axis_tdata};
    end
  end

  // Next head: from memory if an older word remains, else bypass the word arriving now.
  always_comb begin
    w_rx_head_next = {r_ben_o, r_data_o};
    if (w_rx_rd_ptr_next != r_rx_wr_ptr) begin
      w_rx_head_next = r_rx_mem[w_rx_rd_ptr_next[c_RX_AW-1:0]];
    end else if (w_rx_push) begin
      w_rx_head_next = {bus.s_axis_tkeep, bus.s_axis_tdata};
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  // The write that moves IDLE to WR is captured too, so the host's first word is kept.
  assign w_tx_push        = ~bus.ft245_wrn & ~r_txen &
                            (((r_state == ST_IDLE) & bus.ft245_oen) | (r_state == ST_WR));
  assign w_tx_pop         = r_m_axis_tvalid & bus.m_axis_tready;
  assign w_tx_wr_ptr_next = r_tx_wr_ptr + {{c_TX_AW{1'b0}}, w_tx_push};
  assign w_tx_rd_ptr_next = r_tx_rd_ptr + {{c_TX_AW{1'b0}}, w_tx_pop};
  assign w_tx_count_next  = w_tx_wr_ptr_next - w_tx_rd_ptr_next;
  assign w_tx_word        = {bus.ft245_ben_i, ~bus.ft245_siwun, bus.ft245_data_i};

  always_ff @(posedge ft245_dclk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr[c_TX_AW-1:0]] <= w_tx_word;
    end
  end

  // The AXIS output register is the FIFO head, so it counts toward occupancy.
  always_comb begin
    w_tx_head_next = {r_m_axis_tkeep, r_m_axis_tlast, r_m_axis_tdata};
    if (w_tx_rd_ptr_next != r_tx_wr_ptr) begin
      w_tx_head_next = r_tx_mem[w_tx_rd_ptr_next[c_TX_AW-1:0]];
    end else if (w_tx_push) begin
      w_tx_head_next = w_tx_word;
    end
  end

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge ft245_dclk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (!bus.ft245_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!bus.ft245_oen && !r_rxfn) begin
          w_state_next = ST_RD_TURN;
        end else if (!bus.ft245_wrn && !r_txen && bus.ft245_oen) begin
          w_state_next = ST_WR;
        end
      end
      ST_RD_TURN: begin
        if (bus.ft245_oen) begin
          w_state_next = ST_IDLE;
        end else if (!bus.ft245_rdn) begin
          w_state_next = ST_RD;
        end
      end
      ST_RD: begin
        if (bus.ft245_oen) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WR: begin
        if (bus.ft245_wrn) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- registered outputs
  always_ff @(posedge ft245_dclk or posedge rst) begin
    if (rst) begin
      r_rx_wr_ptr     <= '0;
      r_rx_rd_ptr     <= '0;
      r_tx_wr_ptr     <= '0;
      r_tx_rd_ptr     <= '0;
      r_rxfn          <= 1'b1;
      r_txen          <= 1'b1;
      r_data_t        <= 1'b1;
      r_data_o        <= '0;
      r_ben_o         <= '0;
      r_s_axis_tready <= 1'b0;
      r_m_axis_tvalid <= 1'b0;
      r_m_axis_tdata  <= '0;
      r_m_axis_tkeep  <= '0;
      r_m_axis_tlast  <= 1'b0;
    end else if (!bus.ft245_rstn) begin
      r_rx_wr_ptr     <= '0;
      r_rx_rd_ptr     <= '0;
      r_tx_wr_ptr     <= '0;
      r_tx_rd_ptr     <= '0;
      r_rxfn          <= 1'b1;
      r_txen          <= 1'b1;
      r_data_t        <= 1'b1;
      r_data_o        <= '0;
      r_ben_o         <= '0;
      r_s_axis_tready <= 1'b0;
      r_m_axis_tvalid <= 1'b0;
      r_m_axis_tdata  <= '0;
      r_m_axis_tkeep  <= '0;
      r_m_axis_tlast  <= 1'b0;
    end else begin
      r_rx_wr_ptr     <= w_rx_wr_ptr_next;
      r_rx_rd_ptr     <= w_rx_rd_ptr_next;
      r_tx_wr_ptr     <= w_tx_wr_ptr_next;
      r_tx_rd_ptr     <= w_tx_rd_ptr_next;
      r_rxfn          <= (w_rx_count_next == '0);
      r_txen          <= (w_tx_count_next == c_TX_FULL);
      r_s_axis_tready <= (w_rx_count_next != c_RX_FULL);
      r_m_axis_tvalid <= (w_tx_count_next != '0);
      r_data_t        <= !((w_state_next == ST_RD_TURN) || (w_state_next == ST_RD));
      {r_ben_o, r_data_o}                             <= w_rx_head_next;
      {r_m_axis_tkeep, r_m_axis_tlast, r_m_axis_tdata} <= w_tx_head_next;
    end
  end

  assign bus.ft245_data_o  = r_data_o;
  assign bus.ft245_ben_o   = r_ben_o;
  assign bus.ft245_data_t  = r_data_t;
  assign bus.ft245_rxfn    = r_rxfn;
  assign bus.ft245_txen    = r_txen;
  assign bus.s_axis_tready = r_s_axis_tready;
  assign bus.m_axis_tvalid = r_m_axis_tvalid;
  assign bus.m_axis_tdata  = r_m_axis_tdata;
  assign bus.m_axis_tkeep  = r_m_axis_tkeep;
  assign bus.m_axis_tlast  = r_m_axis_tlast;

endmodule
`default_nettype wire

// File: tb/tb_ft245_sync_device_emu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ft245_sync_device_emu
// Brief   : Directed self-checking bench for the FT245 sync device emulator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ft245_sync_device_emu;

  logic tb_data_clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ft245_sync_device_emu_if #(.BUS_WIDTH(1)) bus ();

  ft245_sync_device_emu #(
    .BUS_WIDTH(1),
    .RX_DEPTH (16),
    .TX_DEPTH (16)
  ) dut (
    .ft245_dclk(tb_data_clk),
    .rst       (rst),
    .bus       (bus)
  );

  initial tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  task automatic tick();
    @(posedge tb_data_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic s_push(input logic [7:0] d);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = 1'b1;
    tick();
    bus.s_axis_tvalid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.ft245_data_i  = '0;
    bus.ft245_ben_i   = '0;
    bus.ft245_rdn     = 1'b1;
    bus.ft245_wrn     = 1'b1;
    bus.ft245_oen     = 1'b1;
    bus.ft245_siwun   = 1'b1;
    bus.ft245_rstn    = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_rxfn",   bus.ft245_rxfn,    1);
    chk("rst_txen",   bus.ft245_txen,    1);
    chk("rst_data_t", bus.ft245_data_t,  1);
    chk("rst_data_o", bus.ft245_data_o,  0);
    chk("rst_ben_o",  bus.ft245_ben_o,   0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tdata",  bus.m_axis_tdata,  0);
    rst = 1'b0;
    tick();
    chk("rel_tready", bus.s_axis_tready, 1);
    chk("rel_txen",   bus.ft245_txen,    0);
    chk("rel_rxfn",   bus.ft245_rxfn,    1);

    // 1. host reads 0x41..0x44
    for (int i = 0; i < 4; i++) s_push(8'h41 + 8'(i));
    chk("t1_rxfn_fill", bus.ft245_rxfn,   0);
    chk("t1_data_t_idle", bus.ft245_data_t, 1);
    bus.ft245_oen = 1'b0;
    tick();
    chk("t1_turn_data_t", bus.ft245_data_t, 0);
    chk("t1_turn_data_o", bus.ft245_data_o, 32'h41);
    chk("t1_turn_ben_o",  bus.ft245_ben_o,  1);
    bus.ft245_rdn = 1'b0;
    tick();
    chk("t1_rd_no_pop", bus.ft245_data_o, 32'h41);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_data", bus.ft245_data_o, 32'h41 + i);
      tick();
      chk("t1_rd_rxfn", bus.ft245_rxfn, (i == 3) ? 1 : 0);
    end
    tick();
    chk("t1_empty_rd_ignored", bus.ft245_rxfn, 1);
    chk("t1_still_driving",    bus.ft245_data_t, 0);
    bus.ft245_oen = 1'b1;
    bus.ft245_rdn = 1'b1;
    tick();
    chk("t1_release_data_t", bus.ft245_data_t, 1);

    // 2. host writes 0x10..0x13, send-immediate on last
    bus.m_axis_tready = 1'b1;
    bus.ft245_wrn     = 1'b0;
    bus.ft245_ben_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ft245_data_i = 8'h10 + 8'(i);
      bus.ft245_siwun  = (i == 3) ? 1'b0 : 1'b1;
      tick();
      chk("t2_tvalid", bus.m_axis_tvalid, 1);
      chk("t2_tdata",  bus.m_axis_tdata,  32'h10 + i);
      chk("t2_tlast",  bus.m_axis_tlast,  (i == 3) ? 1 : 0);
      chk("t2_tkeep",  bus.m_axis_tkeep,  1);
      chk("t2_data_t", bus.ft245_data_t,  1);
    end
    bus.ft245_wrn   = 1'b1;
    bus.ft245_siwun = 1'b1;
    tick();
    chk("t2_drained", bus.m_axis_tvalid, 0);

    // 3. overfill TX by two words with sink stalled
    bus.m_axis_tready = 1'b0;
    bus.ft245_wrn     = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.ft245_data_i = 8'h80 + 8'(i);
      tick();
      chk("t3_txen", bus.ft245_txen, (i >= 15) ? 1 : 0);
    end
    bus.ft245_wrn = 1'b1;
    tick();
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_valid", bus.m_axis_tvalid, 1);
      chk("t3_drain_data",  bus.m_axis_tdata,  32'h80 + i);
      tick();
      if (i == 0) chk("t3_txen_free", bus.ft245_txen, 0);
    end
    chk("t3_drain_done", bus.m_axis_tvalid, 0);
    bus.m_axis_tready = 1'b0;

    // 4. full RX, simultaneous push and pop
    for (int i = 0; i < 16; i++) s_push(8'hA0 + 8'(i));
    chk("t4_full_tready", bus.s_axis_tready, 0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 8'hB0;
    bus.ft245_oen     = 1'b0;
    tick();
    bus.ft245_rdn = 1'b0;
    tick();
    chk("t4_blocked_tready", bus.s_axis_tready, 0);
    chk("t4_pop0_data", bus.ft245_data_o, 32'hA0);
    tick();
    chk("t4_pop0_tready", bus.s_axis_tready, 1);
    chk("t4_pop0_rxfn",   bus.ft245_rxfn,    0);
    chk("t4_pop1_data",   bus.ft245_data_o,  32'hA1);
    tick();
    chk("t4_pushpop_tready", bus.s_axis_tready, 1);
    chk("t4_pushpop_rxfn",   bus.ft245_rxfn,    0);
    bus.ft245_rdn    = 1'b1;
    bus.s_axis_tdata = 8'hB1;
    tick();
    bus.s_axis_tvalid = 1'b0;
    chk("t4_refull_tready", bus.s_axis_tready, 0);
    bus.ft245_rdn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t4_order", bus.ft245_data_o, (i < 14) ? (32'hA2 + i) : (32'hB0 + i - 14));
      tick();
    end
    chk("t4_empty_rxfn", bus.ft245_rxfn, 1);
    bus.ft245_oen = 1'b1;
    bus.ft245_rdn = 1'b1;
    tick();

    // 5. async reset in the middle of a read
    s_push(8'hC0);
    s_push(8'hC1);
    bus.ft245_oen = 1'b0;
    tick();
    bus.ft245_rdn = 1'b0;
    tick();
    chk("t5_reading_data_t", bus.ft245_data_t, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_data_t", bus.ft245_data_t, 1);
    chk("t5_async_rxfn",   bus.ft245_rxfn,   1);
    chk("t5_async_txen",   bus.ft245_txen,   1);
    bus.ft245_oen = 1'b1;
    bus.ft245_rdn = 1'b1;
    rst = 1'b0;
    tick();
    chk("t5_release_txen", bus.ft245_txen, 0);
    chk("t5_release_rxfn", bus.ft245_rxfn, 1);

    // 6. host FIFO reset with 5 words in each direction
    for (int i = 0; i < 5; i++) s_push(8'hD0 + 8'(i));
    bus.ft245_wrn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ft245_data_i = 8'hE0 + 8'(i);
      tick();
    end
    bus.ft245_wrn = 1'b1;
    tick();
    chk("t6_pre_rxfn",   bus.ft245_rxfn,    0);
    chk("t6_pre_tvalid", bus.m_axis_tvalid, 1);
    chk("t6_pre_tdata",  bus.m_axis_tdata,  32'hE0);
    bus.ft245_rstn = 1'b0;
    tick();
    bus.ft245_rstn = 1'b1;
    chk("t6_flush_rxfn",   bus.ft245_rxfn,    1);
    chk("t6_flush_tvalid", bus.m_axis_tvalid, 0);
    chk("t6_flush_txen",   bus.ft245_txen,    1);
    chk("t6_flush_tready", bus.s_axis_tready, 0);
    tick();
    chk("t6_after_txen",   bus.ft245_txen,    0);
    chk("t6_after_tready", bus.s_axis_tready, 1);
    chk("t6_after_rxfn",   bus.ft245_rxfn,    1);
    chk("t6_after_tvalid", bus.m_axis_tvalid, 0);
    s_push(8'hD5);
    bus.ft245_oen = 1'b0;
    tick();
    bus.ft245_rdn = 1'b0;
    tick();
    chk("t6_fresh_head", bus.ft245_data_o, 32'hD5);
    tick();
    chk("t6_fresh_empty", bus.ft245_rxfn, 1);
    bus.ft245_oen = 1'b1;
    bus.ft245_rdn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
